// File: rtl/cflog_monitor_gen.sv
// CFLog monitor: tracks PC against ER/TCB and drives the log write pointer; hw_wr_en is registered one cycle after commit, no backpressure (full blocks or wraps).
// Optional CFLOG_WATERMARK_EN adds the WATERMARK parameter and the wm_hit pulse output.
module cflog_monitor_gen #(
  parameter int unsigned AW        = 16,
  parameter int unsigned LOG_SIZE  = 16'h0100,
  parameter int unsigned ENTRY_B   = 2,
  parameter int unsigned WRAP_MODE = 0,
  parameter int unsigned TCB_MIN   = 16'ha000,
  parameter int unsigned TCB_MAX   = 16'hdffe
`ifdef CFLOG_WATERMARK_EN
  , parameter int unsigned WATERMARK = LOG_SIZE * 3 / 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_nxt,
  input  logic [AW-1:0] er_min,
  input  logic [AW-1:0] er_max,
  input  logic          irq,
  input  logic          branch_detect,
  input  logic          loop_detect,
  input  logic          detect_active,
  input  logic [AW-1:0] active_block_cflog_addr,
  output logic          flush,
  output logic          hw_wr_en,
  output logic [AW-1:0] cflow_log_ptr,
  output logic [AW-1:0] cflow_log_prev_ptr,
  output logic          log_full,
  output logic [7:0]    wrap_cnt
`ifdef CFLOG_WATERMARK_EN
  , output logic        wm_hit
`endif
);

  localparam logic [AW:0]   LOG_SZ = (AW+1)'(LOG_SIZE);
  localparam logic [AW-1:0] STEP   = AW'(ENTRY_B);
  localparam logic [AW-1:0] TMIN   = AW'(TCB_MIN);
  localparam logic [AW-1:0] TMAX   = AW'(TCB_MAX);

  typedef enum logic [1:0] {NOT_X, IN_X, WAIT, WRITE} pc_state_t;
  typedef enum logic {EXEC, ABORT} trig_t;

  pc_state_t     pc_state;
  trig_t         trig;
  logic          attest_pend;
  logic [AW:0]   ptr_step;
  logic [AW-1:0] ptr_nxt;
  logic          pc_in_er, nxt_in_er, pc_in_tcb, nxt_in_tcb, tcb_interior;
  logic          entering_er, entering_tcb, room, commit, wrap_evt, flush_set;

  // log_full is evaluated one bit wider so a pointer near the top of the space cannot alias low
  assign ptr_step     = {1'b0, cflow_log_ptr} + {1'b0, STEP};
  assign log_full     = ptr_step >= LOG_SZ;
  assign pc_in_er     = (pc >= er_min) && (pc <= er_max);
  assign nxt_in_er    = (pc_nxt >= er_min) && (pc_nxt <= er_max);
  assign pc_in_tcb    = (pc >= TMIN) && (pc <= TMAX);
  assign nxt_in_tcb   = (pc_nxt >= TMIN) && (pc_nxt <= TMAX);
  assign tcb_interior = (pc > TMIN) && (pc < TMAX);
  assign entering_er  = (pc == TMAX) && nxt_in_er;
  assign entering_tcb = !pc_in_tcb && nxt_in_tcb;
  assign room         = ({1'b0, cflow_log_ptr} < LOG_SZ) && ((WRAP_MODE != 0) || !log_full);
  assign commit       = branch_detect && room &&
                        (((pc_state == NOT_X) && entering_er) || entering_tcb ||
                         (((pc_state == IN_X) || (pc_state == WAIT)) && !loop_detect));
  // a SpecCFA rewind on the wrapping commit takes precedence, so no wrap is recorded
  assign wrap_evt     = (WRAP_MODE != 0) && commit && log_full && !detect_active;

`ifdef CFLOG_WATERMARK_EN
  logic wm_armed, wm_cross;
  assign wm_cross  = wm_armed && ({1'b0, cflow_log_ptr} >= (AW+1)'(WATERMARK));
  assign flush_set = ((WRAP_MODE == 0) && (trig == EXEC) && log_full) || wrap_evt ||
                     ((trig == EXEC) && wm_cross);

  always_ff @(posedge clk) begin
    if (reset) begin
      wm_armed <= 1'b1;
      wm_hit   <= 1'b0;
    end else begin
      wm_hit <= wm_cross;
      if (cflow_log_ptr == '0) wm_armed <= 1'b1;
      else if (wm_cross)       wm_armed <= 1'b0;
    end
  end
`else
  assign flush_set = ((WRAP_MODE == 0) && (trig == EXEC) && log_full) || wrap_evt;
`endif

  always_comb begin
    ptr_nxt = cflow_log_ptr;
    if (commit && detect_active)  ptr_nxt = active_block_cflog_addr + STEP;
    else if (commit)              ptr_nxt = wrap_evt ? '0 : ptr_step[AW-1:0];
    else if (tcb_interior)        ptr_nxt = cflow_log_ptr;
    else if (pc == TMAX)          ptr_nxt = '0;
    else if (detect_active)       ptr_nxt = active_block_cflog_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_state           <= NOT_X;
      trig               <= ABORT;
      attest_pend        <= 1'b0;
      cflow_log_ptr      <= '0;
      cflow_log_prev_ptr <= '0;
      hw_wr_en           <= 1'b0;
      flush              <= 1'b0;
      wrap_cnt           <= 8'd0;
    end else begin
      cflow_log_ptr <= ptr_nxt;
      if (commit) cflow_log_prev_ptr <= cflow_log_ptr;
      hw_wr_en    <= commit && !tcb_interior;
      attest_pend <= irq;
      if (wrap_evt && (wrap_cnt != 8'hFF)) wrap_cnt <= wrap_cnt + 8'd1;

      if (attest_pend)            flush <= 1'b0;
      else if (flush_set)         flush <= 1'b1;
      else if (WRAP_MODE != 0)    flush <= 1'b0;

      if (trig == EXEC) begin
        if ((WRAP_MODE == 0) && log_full) trig <= ABORT;
      end else if (!log_full) begin
        trig <= EXEC;
      end

      case (pc_state)
        NOT_X: if (pc_in_er) pc_state <= IN_X;
        IN_X, WAIT: begin
          if (!pc_in_er)                        pc_state <= NOT_X;
          else if (branch_detect && !log_full)  pc_state <= WRITE;
          else if (pc_state == IN_X)            pc_state <= WAIT;
        end
        WRITE: begin
          if (!pc_in_er)                        pc_state <= NOT_X;
          else if (!branch_detect || log_full)  pc_state <= WAIT;
        end
        default: pc_state <= NOT_X;
      endcase
    end
  end

endmodule

// File: tb/tb_cflog_monitor_gen.sv
// Bench for cflog_monitor_gen: three instances (256-byte stop, 8-byte stop, 8-byte wrap) share stimulus.
module tb_cflog_monitor_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, pc_nxt, er_min, er_max, addr;
  logic        irq, br, loop_d, da;

  logic        d_fl, d_wr, d_full, s_fl, s_wr, s_full, w_fl, w_wr, w_full;
  logic [15:0] d_ptr, d_prev, s_ptr, s_prev, w_ptr, w_prev;
  logic [7:0]  d_wc, s_wc, w_wc;
`ifdef CFLOG_WATERMARK_EN
  logic        d_wm, s_wm, w_wm;
`endif

  always #5 clk = ~clk;

  cflog_monitor_gen #(.LOG_SIZE(16'h0100), .WRAP_MODE(0)) u_dflt (
    .clk(clk), .reset(rst), .pc(pc), .pc_nxt(pc_nxt), .er_min(er_min), .er_max(er_max),
    .irq(irq), .branch_detect(br), .loop_detect(loop_d), .detect_active(da),
    .active_block_cflog_addr(addr), .flush(d_fl), .hw_wr_en(d_wr), .cflow_log_ptr(d_ptr),
    .cflow_log_prev_ptr(d_prev), .log_full(d_full), .wrap_cnt(d_wc)
`ifdef CFLOG_WATERMARK_EN
    , .wm_hit(d_wm)
`endif
  );

  cflog_monitor_gen #(.LOG_SIZE(8), .WRAP_MODE(0)) u_stop (
    .clk(clk), .reset(rst), .pc(pc), .pc_nxt(pc_nxt), .er_min(er_min), .er_max(er_max),
    .irq(irq), .branch_detect(br), .loop_detect(loop_d), .detect_active(da),
    .active_block_cflog_addr(addr), .flush(s_fl), .hw_wr_en(s_wr), .cflow_log_ptr(s_ptr),
    .cflow_log_prev_ptr(s_prev), .log_full(s_full), .wrap_cnt(s_wc)
`ifdef CFLOG_WATERMARK_EN
    , .wm_hit(s_wm)
`endif
  );

  cflog_monitor_gen #(.LOG_SIZE(8), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset(rst), .pc(pc), .pc_nxt(pc_nxt), .er_min(er_min), .er_max(er_max),
    .irq(irq), .branch_detect(br), .loop_detect(loop_d), .detect_active(da),
    .active_block_cflog_addr(addr), .flush(w_fl), .hw_wr_en(w_wr), .cflow_log_ptr(w_ptr),
    .cflow_log_prev_ptr(w_prev), .log_full(w_full), .wrap_cnt(w_wc)
`ifdef CFLOG_WATERMARK_EN
    , .wm_hit(w_wm)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: log behaviour stated as rules over plain integers
  localparam int NOTX = 0, INX = 1, WT = 2, WRT = 3;
  localparam int EXEC = 0, ABORT = 1;
  localparam int TMIN = 'hA000, TMAX = 'hDFFE, STEP = 2;

  typedef struct {
    int st; int trig; int ap; int ptr; int prev; int wr; int flush; int wc;
  } mst_t;

  mst_t md, ms, mw;

  function automatic mst_t mreset();
    mst_t r;
    r.st = NOTX; r.trig = ABORT; r.ap = 0; r.ptr = 0; r.prev = 0;
    r.wr = 0; r.flush = 0; r.wc = 0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t s, int ls, bit wrapm);
    mst_t n = s;
    int  p       = s.ptr;
    bit  full    = (p + STEP) >= ls;
    bit  in_er   = (int'(pc) >= int'(er_min)) && (int'(pc) <= int'(er_max));
    bit  nx_er   = (int'(pc_nxt) >= int'(er_min)) && (int'(pc_nxt) <= int'(er_max));
    bit  in_tcb  = (int'(pc) >= TMIN) && (int'(pc) <= TMAX);
    bit  nx_tcb  = (int'(pc_nxt) >= TMIN) && (int'(pc_nxt) <= TMAX);
    bit  tcb_int = (int'(pc) > TMIN) && (int'(pc) < TMAX);
    bit  room, cmt, wrp;
    if (rst) return mreset();
    room = (p < ls) && (wrapm || !full);
    cmt  = br && room && (((s.st == NOTX) && (int'(pc) == TMAX) && nx_er) ||
                          (!in_tcb && nx_tcb) ||
                          (((s.st == INX) || (s.st == WT)) && !loop_d));
    wrp  = wrapm && cmt && full && !da;
    if (cmt && da)              n.ptr = (int'(addr) + STEP) % 65536;
    else if (cmt)               n.ptr = wrp ? 0 : p + STEP;
    else if (tcb_int)           n.ptr = p;
    else if (int'(pc) == TMAX)  n.ptr = 0;
    else if (da)                n.ptr = int'(addr);
    n.wr = (cmt && !tcb_int) ? 1 : 0;
    if (cmt) n.prev = p;
    if (wrp && s.wc < 255) n.wc = s.wc + 1;
    n.ap = irq ? 1 : 0;
    if (s.ap != 0)                                         n.flush = 0;
    else if ((!wrapm && s.trig == EXEC && full) || wrp)    n.flush = 1;
    else if (wrapm)                                        n.flush = 0;
    if (s.trig == EXEC) begin
      if (!wrapm && full) n.trig = ABORT;
    end else if (!full) n.trig = EXEC;
    if (s.st == NOTX) begin
      if (in_er) n.st = INX;
    end else if (!in_er) n.st = NOTX;
    else if (s.st == WRT) begin
      if (!br || full) n.st = WT;
    end else if (br && !full) n.st = WRT;
    else n.st = WT;
    return n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    md = mstep(md, 256, 1'b0);
    ms = mstep(ms, 8, 1'b0);
    mw = mstep(mw, 8, 1'b1);
    #1;
  endtask

  task automatic drv(input bit r, input int p, input int pn, input bit b, input bit d,
                     input int a, input bit q);
    rst = r; pc = 16'(p); pc_nxt = 16'(pn); br = b; da = d; addr = 16'(a); irq = q;
    loop_d = 1'b0;
  endtask

  task automatic cmp_inst(input string tg, input mst_t m, input int ls, input int ptr,
                          input int prev, input int wr, input int fl, input int full, input int wc);
    chk({tg, ".ptr"}, ptr, m.ptr);
    chk({tg, ".prev"}, prev, m.prev);
    chk({tg, ".wr"}, wr, m.wr);
    chk({tg, ".flush"}, fl, m.flush);
    chk({tg, ".full"}, full, ((m.ptr + STEP) >= ls) ? 1 : 0);
    chk({tg, ".wc"}, wc, m.wc);
  endtask

  function automatic int pick_pc();
    int k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return 'hE000 + 2 * $urandom_range(0, 127);
      4:          return TMAX;
      5:          return TMIN;
      6:          return 'hB000 + 2 * $urandom_range(0, 255);
      7:          return 'hE100;
      default:    return 'h1000 + 2 * $urandom_range(0, 255);
    endcase
  endfunction

  typedef struct {
    bit rst; bit br; bit irq;
    int dptr, dwr, sptr, swr, sprev, sfl, wptr, wwr, wprev, wfl, wcnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    md = mreset(); ms = mreset(); mw = mreset();
    er_min = 16'hE000; er_max = 16'hE0FF;
    drv(1, 'hE010, 'hE012, 0, 0, 0, 0);

    //          rst br irq dptr dwr sptr swr sprev sfl wptr wwr wprev wfl wcnt
    tbl[0]  = '{1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0,  2, 1,  2, 1, 0, 0,  2, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,  2, 0,  2, 0, 0, 0,  2, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0,  4, 1,  4, 1, 2, 0,  4, 1, 2, 0, 0};
    tbl[6]  = '{0, 0, 0,  4, 0,  4, 0, 2, 0,  4, 0, 2, 0, 0};
    tbl[7]  = '{0, 1, 0,  6, 1,  6, 1, 4, 0,  6, 1, 4, 0, 0};
    tbl[8]  = '{0, 0, 0,  6, 0,  6, 0, 4, 1,  6, 0, 4, 0, 0};
    tbl[9]  = '{0, 1, 0,  8, 1,  6, 0, 4, 1,  0, 1, 6, 1, 1};
    tbl[10] = '{0, 0, 0,  8, 0,  6, 0, 4, 1,  0, 0, 6, 0, 1};
    tbl[11] = '{0, 1, 0, 10, 1,  6, 0, 4, 1,  2, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 10, 0,  6, 0, 4, 1,  2, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 10, 0,  6, 0, 4, 0,  2, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 10, 0,  6, 0, 4, 0,  2, 0, 0, 0, 1};

    for (int i = 0; i < 15; i++) begin
      drv(tbl[i].rst, 'hE010, 'hE012, tbl[i].br, 0, 0, tbl[i].irq);
      cyc();
      chk($sformatf("tbl%0d.d_ptr", i), int'(d_ptr), tbl[i].dptr);
      chk($sformatf("tbl%0d.d_wr", i), int'(d_wr), tbl[i].dwr);
      chk($sformatf("tbl%0d.s_ptr", i), int'(s_ptr), tbl[i].sptr);
      chk($sformatf("tbl%0d.s_wr", i), int'(s_wr), tbl[i].swr);
      chk($sformatf("tbl%0d.s_prev", i), int'(s_prev), tbl[i].sprev);
      chk($sformatf("tbl%0d.s_flush", i), int'(s_fl), tbl[i].sfl);
      chk($sformatf("tbl%0d.w_ptr", i), int'(w_ptr), tbl[i].wptr);
      chk($sformatf("tbl%0d.w_wr", i), int'(w_wr), tbl[i].wwr);
      chk($sformatf("tbl%0d.w_prev", i), int'(w_prev), tbl[i].wprev);
      chk($sformatf("tbl%0d.w_flush", i), int'(w_fl), tbl[i].wfl);
      chk($sformatf("tbl%0d.w_wc", i), int'(w_wc), tbl[i].wcnt);
    end
    chk("s_full_after_fill", int'(s_full), 1);

    // SpecCFA rewind without and with a branch
    drv(1, 'hE010, 'hE012, 0, 0, 0, 0); cyc(); cyc();
    drv(0, 'hE010, 'hE012, 0, 1, 'h10, 0); cyc();
    chk("rewind_set10", int'(d_ptr), 'h10);
    drv(0, 'hE010, 'hE012, 0, 1, 'h4, 0); cyc();
    chk("rewind_nobr_ptr", int'(d_ptr), 'h4);
    chk("rewind_nobr_wr", int'(d_wr), 0);
    drv(0, 'hE010, 'hE012, 0, 1, 'h10, 0); cyc();
    drv(0, 'hE010, 'hE012, 1, 1, 'h4, 0); cyc();
    chk("rewind_br_ptr", int'(d_ptr), 'h6);
    chk("rewind_br_wr", int'(d_wr), 1);
    chk("rewind_br_prev", int'(d_prev), 'h10);

    // TCB exit into ER, TCB interior, TCB_MAX reset of pointer, TCB entry
    drv(1, 'hE010, 'hE012, 0, 0, 0, 0); cyc(); cyc();
    drv(0, 'hDFFE, 'hE010, 1, 0, 0, 0); cyc();
    chk("tcb_exit_wr", int'(d_wr), 1);
    chk("tcb_exit_prev", int'(d_prev), 0);
    chk("tcb_exit_ptr", int'(d_ptr), 2);
    drv(0, 'hB000, 'hB002, 1, 0, 0, 0); cyc();
    chk("tcb_int_wr", int'(d_wr), 0);
    chk("tcb_int_ptr", int'(d_ptr), 2);
    drv(0, 'hDFFE, 'hDFFE, 0, 0, 0, 0); cyc();
    chk("tcb_max_ptr", int'(d_ptr), 0);
    drv(0, 'h1000, 'hA000, 1, 0, 0, 0); cyc();
    chk("tcb_entry_wr", int'(d_wr), 1);
    chk("tcb_entry_ptr", int'(d_ptr), 2);

    // Randomised run against the model, including mid-run resets
    drv(1, 'hE010, 'hE012, 0, 0, 0, 0); cyc();
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 99) < 2);
      pc     = 16'(pick_pc());
      pc_nxt = 16'(($urandom_range(0, 1) != 0) ? int'(pc) + 2 : pick_pc());
      br     = ($urandom_range(0, 99) < 55);
      loop_d = ($urandom_range(0, 99) < 15);
      da     = ($urandom_range(0, 99) < 8);
      addr   = 16'(2 * $urandom_range(0, 5));
      irq    = ($urandom_range(0, 99) < 5);
      cyc();
      cmp_inst("rnd.dflt", md, 256, int'(d_ptr), int'(d_prev), int'(d_wr), int'(d_fl), int'(d_full), int'(d_wc));
      cmp_inst("rnd.stop", ms, 8, int'(s_ptr), int'(s_prev), int'(s_wr), int'(s_fl), int'(s_full), int'(s_wc));
      cmp_inst("rnd.wrap", mw, 8, int'(w_ptr), int'(w_prev), int'(w_wr), int'(w_fl), int'(w_full), int'(w_wc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
